// File: rtl/csa_result_unpacker_pkg.sv
// csa_result_unpacker_pkg: shared widths, record layout offsets and FSM encoding
package csa_result_unpacker_pkg;
   localparam int AXI_DATA_WIDTH = 32;
   localparam int CSA_IN_PARAMETER_LENGTH = AXI_DATA_WIDTH * 5;
   localparam int CSA_OUT_PARAMETER_LENGTH = AXI_DATA_WIDTH * 7;
   localparam int WORDS = CSA_OUT_PARAMETER_LENGTH / AXI_DATA_WIDTH;
   localparam int IN_WORDS = CSA_IN_PARAMETER_LENGTH / AXI_DATA_WIDTH;
   localparam int RDATA_LATENCY = 1;
   localparam int IDX_W = 3;
   localparam int LAT_W = 4;
   localparam int CNT_W = 32;
   localparam int W_BLOCK = 0;
   localparam int W_IN = 1;
   localparam int W_TIMES = 3;
   localparam int W_TIMES_START = 4;
   localparam int W_OUT = 5;
   typedef enum logic [1:0] {
      S_IDLE,
      S_POP,
      S_WAIT,
      S_SEND
   } state_e;
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/csa_result_unpacker_if.sv
// csa_result_unpacker_if: FIFO read port plus serialized result stream
interface csa_result_unpacker_if;
   import csa_result_unpacker_pkg::*;
   logic                                csa_out_ready;
   logic                                csa_out_ren;
   logic [CSA_OUT_PARAMETER_LENGTH-1:0] csa_out;
   logic                                res_valid;
   logic                                res_ready;
   logic [AXI_DATA_WIDTH-1:0]           res_data;
   logic [IDX_W-1:0]                    res_index;
   logic                                res_last;
   modport master (
      input  csa_out_ready, csa_out, res_ready,
      output csa_out_ren, res_valid, res_data, res_index, res_last
   );
   modport slave (
      output csa_out_ready, csa_out, res_ready,
      input  csa_out_ren, res_valid, res_data, res_index, res_last
   );
endinterface

// File: rtl/csa_result_unpacker.sv
// csa_result_unpacker: pops packed CSA results from the FIFO and streams them out word by word
module csa_result_unpacker
   import csa_result_unpacker_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   csa_result_unpacker_if.master bus,
   output logic [CNT_W-1:0]     res_count,
   output logic                 busy
);
   state_e                              state_q, state_d;
   logic [LAT_W-1:0]                    lat_q, lat_d;
   logic [CSA_OUT_PARAMETER_LENGTH-1:0] rec_q, rec_d;
   logic [AXI_DATA_WIDTH-1:0]           data_q, data_d;
   logic [IDX_W-1:0]                    idx_q, idx_d;
   logic [CNT_W-1:0]                    count_q, count_d;
   logic                                valid_q, valid_d;
   logic                                last_q, last_d;
   logic                                ren_q, ren_d;
   logic                                fire;
   assign fire = valid_q && bus.res_ready;
   // rec_q holds the words not yet presented, shifted down so word k+1 sits at the bottom
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      rec_d   = rec_q;
      data_d  = data_q;
      idx_d   = idx_q;
      count_d = count_q;
      valid_d = valid_q;
      last_d  = last_q;
      ren_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.csa_out_ready) begin
               ren_d   = 1'b1;
               state_d = S_POP;
            end
         end
         S_POP: begin
            lat_d   = LAT_W'(RDATA_LATENCY - 1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (lat_q == '0) begin
               rec_d   = bus.csa_out >> AXI_DATA_WIDTH;
               data_d  = bus.csa_out[AXI_DATA_WIDTH-1:0];
               idx_d   = '0;
               last_d  = 1'b0;
               valid_d = 1'b1;
               state_d = S_SEND;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         S_SEND: begin
            if (fire && last_q) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               idx_d   = '0;
               count_d = sat_inc(count_q);
               state_d = S_IDLE;
            end else if (fire) begin
               data_d = rec_q[AXI_DATA_WIDTH-1:0];
               rec_d  = rec_q >> AXI_DATA_WIDTH;
               idx_d  = idx_q + 1'b1;
               last_d = idx_q == IDX_W'(WORDS - 2);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         lat_q   <= '0;
         rec_q   <= '0;
         data_q  <= '0;
         idx_q   <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         ren_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         rec_q   <= rec_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         ren_q   <= ren_d;
      end
   end
   assign bus.csa_out_ren = ren_q;
   assign bus.res_valid   = valid_q;
   assign bus.res_data    = data_q;
   assign bus.res_index   = idx_q;
   assign bus.res_last    = last_q;
   assign res_count       = count_q;
   assign busy            = state_q != S_IDLE;
endmodule

// File: tb/tb_csa_result_unpacker.sv
// tb_csa_result_unpacker: FIFO model plus scoreboard checking serialized result words
module tb_csa_result_unpacker;
   import csa_result_unpacker_pkg::*;
   typedef logic [CSA_OUT_PARAMETER_LENGTH-1:0] rec_t;
   typedef struct {
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [IDX_W-1:0]          idx;
      logic                      last;
   } beat_t;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [CNT_W-1:0] res_count;
   logic             busy;
   int               total = 0;
   int               bad = 0;
   int               rr_mode = 0;
   logic [CNT_W-1:0] model_count = '0;
   beat_t            exp_q[$];
   rec_t             fifo_q[$];
   csa_result_unpacker_if bus();
   csa_result_unpacker dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .res_count(res_count),
      .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, wanted %0h", name, act, req);
      end
   endtask
   task automatic push_rec(input rec_t r);
      fifo_q.push_back(r);
      for (int k = 0; k < WORDS; k++)
         exp_q.push_back('{r[AXI_DATA_WIDTH*k +: AXI_DATA_WIDTH], IDX_W'(k), k == WORDS - 1});
   endtask
   function automatic rec_t rand_rec();
      rec_t r;
      for (int k = 0; k < WORDS; k++) r[AXI_DATA_WIDTH*k +: AXI_DATA_WIDTH] = $urandom;
      return r;
   endfunction
   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy) && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("drain_in_time", 64'(n < 3000), 1);
      @(negedge clk);
      #1;
      chk("res_count", res_count, model_count);
   endtask
   initial begin
      int ph;
      ph = 0;
      bus.res_ready = 1'b1;
      forever begin
         @(negedge clk);
         ph++;
         bus.res_ready = rr_mode == 0 ? 1'b1 :
                         rr_mode == 1 ? (ph % 4 == 0 || ph % 4 == 3) :
                         1'($urandom_range(0, 1));
      end
   end
   initial begin
      bus.csa_out = '0;
      bus.csa_out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.csa_out_ren) begin
            total++;
            if (fifo_q.size() == 0) begin
               bad++;
               $display("FAIL fifo_read: ren=1 with fifo empty, wanted no read");
            end else begin
               bus.csa_out = fifo_q.pop_front();
            end
         end
         bus.csa_out_ready = fifo_q.size() != 0;
      end
   end
   initial begin
      beat_t e, held;
      logic  hold, pend, ren_prev, ren_seen;
      int    cyc, last_ren;
      hold = 1'b0; pend = 1'b0; ren_prev = 1'b0; ren_seen = 1'b0;
      cyc = 0; last_ren = 0;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (rst) begin
            hold = 1'b0; pend = 1'b0; ren_prev = 1'b0; ren_seen = 1'b0;
         end else begin
            if (pend) chk("count_after_record", res_count, model_count);
            pend = 1'b0;
            if (bus.csa_out_ren) begin
               chk("ren_single_cycle", 64'(ren_prev), 0);
               if (ren_seen && !ren_prev) chk("ren_gap_min", 64'((cyc - last_ren) >= WORDS + 3), 1);
               if (!ren_prev) begin
                  last_ren = cyc;
                  ren_seen = 1'b1;
               end
            end
            ren_prev = bus.csa_out_ren;
            if (hold)
               chk("stall_stable", {bus.res_valid, bus.res_data, bus.res_index, bus.res_last},
                   {1'b1, held.data, held.idx, held.last});
            hold = 1'b0;
            if (bus.res_valid && bus.res_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL beat_extra: got data %0h idx %0d, wanted no beat", bus.res_data, bus.res_index);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat", {bus.res_data, bus.res_index, bus.res_last}, {e.data, e.idx, e.last});
                  if (e.last) begin
                     model_count = (model_count == 32'hFFFF_FFFF) ? model_count : model_count + 1;
                     pend = 1'b1;
                  end
               end
            end else if (bus.res_valid) begin
               hold = 1'b1;
               held = '{bus.res_data, bus.res_index, bus.res_last};
            end
         end
      end
   end
   initial begin
      rec_t r;
      int   n;
      for (int k = 0; k < WORDS; k++) r[AXI_DATA_WIDTH*k +: AXI_DATA_WIDTH] = 32'h10 + k;
      push_rec(r);
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ren", 64'(bus.csa_out_ren), 0);
      chk("rst_valid", 64'(bus.res_valid), 0);
      chk("rst_data", bus.res_data, 0);
      chk("rst_index", bus.res_index, 0);
      chk("rst_last", 64'(bus.res_last), 0);
      chk("rst_count", res_count, 0);
      chk("rst_busy", 64'(busy), 0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("ren_after_release", 64'(bus.csa_out_ren), 1);
      @(negedge clk);
      #1;
      chk("ren_drops", 64'(bus.csa_out_ren), 0);
      n = 2;
      while (busy && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("ren_to_idle_cycles", n, WORDS + 3);
      drain();
      rr_mode = 1;
      repeat (2) push_rec(rand_rec());
      drain();
      rr_mode = 2;
      repeat (3) push_rec(rand_rec());
      drain();
      rr_mode = 0;
      repeat (3) push_rec(rand_rec());
      drain();
      push_rec(rand_rec());
      n = 0;
      while (!(bus.res_valid && bus.res_index == 3) && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("reached_beat3", 64'(n < 100), 1);
      rst = 1'b1;
      exp_q.delete();
      model_count = '0;
      @(negedge clk);
      #1;
      chk("midrst_valid", 64'(bus.res_valid), 0);
      chk("midrst_count", res_count, 0);
      chk("midrst_busy", 64'(busy), 0);
      rst = 1'b0;
      push_rec(rand_rec());
      drain();
      @(negedge clk);
      force dut.count_q = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.count_q;
      #1;
      model_count = 32'hFFFF_FFFE;
      chk("count_preset", res_count, 32'hFFFF_FFFE);
      rr_mode = 2;
      repeat (2) push_rec(rand_rec());
      drain();
      chk("count_saturated", res_count, 32'hFFFF_FFFF);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
